// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Parametrised CPU register file (R0-R7, IH, SP, RA) with a T flag and a
//   per-register pending-write scoreboard. The decode stage reads operands
//   combinationally and issues writers; the write-back stage retires them.
//   Index 0 and any index >= NUM_REGS are null: they read 0 and are always
//   ready, and writes and issues to them are dropped.
//
//   Optional build macro: REGFILE_BYPASS_EN
//     defined   - a write-back in flight is forwarded to matching read ports
//                 (data and readiness), and t_data is forwarded to t_q.
//     undefined - reads and t_q reflect registered state only.
//
// Ports
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   rd_idx      NUM_RD packed read indices (port k at [k*ADDR_W +: ADDR_W])
//   rd_data     NUM_RD packed read values, same packing
//   rd_ready    per port: operand has no outstanding write
//   issue_en    decode issues an instruction writing issue_idx
//   issue_idx   destination of the issued instruction
//   issue_full  pending counter of issue_idx saturated; issue refused
//   wb_en       write-back valid
//   wb_idx      write-back destination
//   wb_data     write-back value
//   t_we        T flag write enable
//   t_data      T flag value
//   t_q         current T flag
//   wb_err      sticky: a write-back retired against a zero pending count
//   regs_flat   all registers, register 0 in the MSBs
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 11,
  parameter int NUM_RD   = 2,
  parameter int PEND_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_idx,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_ready,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_idx,
  output logic                       issue_full,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_idx,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       t_we,
  input  logic                       t_data,
  output logic                       t_q,
  output logic                       wb_err,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1'b1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  logic [DATA_W-1:0] regFile_r      [NUM_REGS];
  logic [PEND_W-1:0] pendCnt_r      [NUM_REGS];
  logic [PEND_W-1:0] pendCntNext_s  [NUM_REGS];
  logic              tFlag_r;
  logic              wbErr_r;
  logic              errSet_s;
  logic              wbValid_s;
  logic              issueAccept_s;
  logic [NUM_RD-1:0] fwdHit_s;

  // A live index names an implemented register other than the hardwired R0.
  function automatic logic isLive(input logic [ADDR_W-1:0] idx);
    return (idx != {ADDR_W{1'b0}}) && (int'(idx) < NUM_REGS);
  endfunction

  assign wbValid_s     = wb_en && isLive(wb_idx);
  assign issue_full    = issue_en && isLive(issue_idx) && (pendCnt_r[issue_idx] == PEND_MAX);
  assign issueAccept_s = issue_en && isLive(issue_idx) && !issue_full;

  // Per read port: is the in-flight write-back being forwarded to it?
  always_comb begin
    fwdHit_s = {NUM_RD{1'b0}};
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < NUM_RD; k++) begin
      if (wbValid_s && (wb_idx == rd_idx[k*ADDR_W +: ADDR_W])) begin
        fwdHit_s[k] = 1'b1;
      end else begin
        fwdHit_s[k] = 1'b0;
      end
    end
`endif
  end

  // Combinational read ports; a forwarded write-back also retires the last
  // pending write, so a count of one is then safe to read.
  always_comb begin
    rd_data  = {(NUM_RD*DATA_W){1'b0}};
    rd_ready = {NUM_RD{1'b1}};
    for (int k = 0; k < NUM_RD; k++) begin
      if (!isLive(rd_idx[k*ADDR_W +: ADDR_W])) begin
        rd_data[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rd_ready[k]                 = 1'b1;
      end else if (fwdHit_s[k]) begin
        rd_data[k*DATA_W +: DATA_W] = wb_data;
        rd_ready[k] = (pendCnt_r[rd_idx[k*ADDR_W +: ADDR_W]] == PEND_ZERO) ||
                      (pendCnt_r[rd_idx[k*ADDR_W +: ADDR_W]] == PEND_ONE);
      end else begin
        rd_data[k*DATA_W +: DATA_W] = regFile_r[rd_idx[k*ADDR_W +: ADDR_W]];
        rd_ready[k] = (pendCnt_r[rd_idx[k*ADDR_W +: ADDR_W]] == PEND_ZERO);
      end
    end
  end

  // Scoreboard next state: issue and write-back to the same register cancel;
  // a write-back against a zero count flags an error instead of wrapping.
  always_comb begin
    errSet_s = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pendCntNext_s[i] = pendCnt_r[i];
      case ({issueAccept_s && (issue_idx == ADDR_W'(i)),
             wbValid_s     && (wb_idx    == ADDR_W'(i))})
        2'b10: pendCntNext_s[i] = pendCnt_r[i] + PEND_ONE;
        2'b01: begin
          if (pendCnt_r[i] != PEND_ZERO) begin
            pendCntNext_s[i] = pendCnt_r[i] - PEND_ONE;
          end else begin
            errSet_s = 1'b1;
          end
        end
        default: pendCntNext_s[i] = pendCnt_r[i];
      endcase
    end
  end

  // Register file, scoreboard, T flag and sticky error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile_r[i] <= {DATA_W{1'b0}};
        pendCnt_r[i] <= PEND_ZERO;
      end
      tFlag_r <= 1'b0;
      wbErr_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pendCnt_r[i] <= pendCntNext_s[i];
        if (wbValid_s && (wb_idx == ADDR_W'(i))) begin
          regFile_r[i] <= wb_data;
        end
      end
      if (t_we) begin
        tFlag_r <= t_data;
      end
      if (errSet_s) begin
        wbErr_r <= 1'b1;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign t_q = t_we ? t_data : tFlag_r;
`else
  assign t_q = tFlag_r;
`endif

  assign wb_err = wbErr_r;

  // Debug bus in VGA order: register 0 occupies the most significant slice.
  always_comb begin
    regs_flat = {(NUM_REGS*DATA_W){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_flat[(NUM_REGS-1-i)*DATA_W +: DATA_W] = regFile_r[i];
    end
  end

endmodule
